// File: rtl/demux_arbiter_if.sv
// Handshake/bus bundle between the requesting units and demux_arbiter.
//   i_req          : per-requester level request
//   i_release      : current owner is done
//   o_grant_valid  : a grant is active
//   o_grant_sel    : binary index of the owner, feeds the demux select
//   o_grant_onehot : one-hot grant, zero when no grant is active
//   o_timeout      : one-cycle pulse on a forced release
// Modports: master = arbiter side (drives grants), slave = requester side.
interface demux_arbiter_if #(
  parameter int unsigned NUM_REQUESTERS = 5
);
  localparam int unsigned SEL_W = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0] i_req;
  logic                      i_release;
  logic                      o_grant_valid;
  logic [SEL_W-1:0]          o_grant_sel;
  logic [NUM_REQUESTERS-1:0] o_grant_onehot;
  logic                      o_timeout;

  modport master (
    input  i_req,
    input  i_release,
    output o_grant_valid,
    output o_grant_sel,
    output o_grant_onehot,
    output o_timeout
  );

  modport slave (
    output i_req,
    output i_release,
    input  o_grant_valid,
    input  o_grant_sel,
    input  o_grant_onehot,
    input  o_timeout
  );
endinterface

// File: rtl/demux_arbiter.sv
// Round-robin arbiter sharing one demux-driven resource among NUM_REQUESTERS
// requesters. A grant is held until the owner releases it or withdraws its
// request; one idle bubble always separates consecutive grants so the demux
// output can settle. All outputs are registered.
//
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : demux_arbiter_if.master (requests/release in, grants/timeout out)
//
// Optional feature, macro ARB_TIMEOUT_EN: when defined, a grant that has been
// held MAX_HOLD cycles without release is forcibly released and o_timeout
// pulses for one cycle. When undefined, o_timeout is constant 0 and grants
// are held indefinitely.
module demux_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 5,
  parameter int unsigned MAX_HOLD       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  demux_arbiter_if.master  bus
);

  localparam int unsigned N     = NUM_REQUESTERS;
  localparam int unsigned SEL_W = $clog2(N);

  // Elaboration-time parameter sanity check.
  if (N < 2 || N > 32 || MAX_HOLD < 1) begin : g_param_check
    $error("demux_arbiter: illegal NUM_REQUESTERS or MAX_HOLD");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q,  state_d;
  logic [SEL_W-1:0] ptr_q,    ptr_d;
  logic [SEL_W-1:0] sel_q,    sel_d;
  logic             valid_q,  valid_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic             timeout_q, timeout_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              expire_c;
`endif

  logic             win_found_c;
  logic [SEL_W-1:0] win_idx_c;
  logic [SEL_W:0]   cand_c;
  logic             owner_release_c;
  logic [SEL_W-1:0] ptr_after_sel_c;

  // Round-robin winner: first set request scanning upward from the pointer,
  // wrapping at N. cand_c is one bit wider so ptr+i never overflows before
  // the wrap subtraction.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_c = {1'b0, ptr_q} + (SEL_W+1)'(i);
      if (cand_c >= (SEL_W+1)'(N)) begin
        cand_c = cand_c - (SEL_W+1)'(N);
      end
      if (!win_found_c && bus.i_req[cand_c[SEL_W-1:0]]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c[SEL_W-1:0];
      end
    end
  end

  // Withdrawal of the owner's request counts as a release.
  assign owner_release_c = bus.i_release || !bus.i_req[sel_q];

  // Pointer after a release: one past the owner, never loaded with >= N.
  assign ptr_after_sel_c = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + SEL_W'(1);

`ifdef ARB_TIMEOUT_EN
  assign expire_c = (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    onehot_d  = onehot_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found_c) begin
          state_d             = GRANT;
          valid_d             = 1'b1;
          sel_d               = win_idx_c;
          onehot_d            = '0;
          onehot_d[win_idx_c] = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d              = '0;
`endif
        end
      end
      GRANT: begin
        if (owner_release_c) begin
          state_d  = IDLE;
          valid_d  = 1'b0;
          onehot_d = '0;
          ptr_d    = ptr_after_sel_c;
`ifdef ARB_TIMEOUT_EN
        end else if (expire_c) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          onehot_d  = '0;
          ptr_d     = ptr_after_sel_c;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      onehot_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      onehot_q  <= onehot_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Grant age counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign bus.o_grant_valid  = valid_q;
  assign bus.o_grant_sel    = sel_q;
  assign bus.o_grant_onehot = onehot_q;
  assign bus.o_timeout      = timeout_q;

endmodule

// File: doc/demux_arbiter.md
Name: demux_arbiter

Overview:
- Round-robin arbiter that shares one demux-driven resource (bus, write port, functional unit) among NUM_REQUESTERS requesters.
- Produces a registered binary select that feeds the demux i_select directly, plus a matching one-hot grant vector.
- Holds each grant until the owner releases it or withdraws its request.
- Sits between requesting pipeline units and the demux.

Parameters:
- NUM_REQUESTERS, 5: number of requesters. Legal range 2..32; need not be a power of two.
- MAX_HOLD, 16: maximum grant length in cycles. Used only when ARB_TIMEOUT_EN is defined. Must be ≥1.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req  input  NUM_REQUESTERS  per-requester request, level-sensitive.
- i_release  input  1  current owner is done; sampled only in GRANT state.
- o_grant_valid  output  1  a grant is active.
- o_grant_sel  output  $clog2(NUM_REQUESTERS)  index of the owner; drives the demux select.
- o_grant_onehot  output  NUM_REQUESTERS  one-hot grant; all zeros when o_grant_valid=0.
- o_timeout  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, priority pointer=0.
  - o_grant_valid=0, o_grant_sel=0, o_grant_onehot=0, o_timeout=0.
  - Reset asserted mid-grant clears everything without waiting for a clock edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- State IDLE:
  - If i_req != 0, the winner is the first set bit scanning upward from the pointer, wrapping from NUM_REQUESTERS-1 to 0.
  - Next edge: state=GRANT, o_grant_valid=1, o_grant_sel=winner, o_grant_onehot=1<<winner.
  - Latency from request to grant is 1 cycle.
  - If i_req == 0, stay in IDLE.
- State GRANT, release condition:
  - Release when i_release=1, OR i_req[o_grant_sel]=0 (withdrawal counts as release).
  - Next edge: state=IDLE, o_grant_valid=0, o_grant_onehot=0.
  - o_grant_sel holds its last value (don't-care for consumers).
  - pointer = (sel+1) mod NUM_REQUESTERS, wrapping N-1 to 0.
  - The pointer is never loaded with an index ≥ NUM_REQUESTERS.
- State GRANT, no release condition: hold the grant; the select is stable for the whole grant.
- Requests from non-owners during GRANT are ignored. They are considered in the next IDLE cycle.
- Mandatory one-cycle bubble between consecutive grants, even with requests pending. This lets the demux output settle.
- Simultaneous i_release and new requests: release first, then arbitrate in the following IDLE cycle.
- i_release asserted in IDLE has no effect.
- Fairness: under continuous all-ones requests, each requester is granted once per NUM_REQUESTERS grants.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If a grant has been valid for MAX_HOLD cycles without a release, it is forcibly released: o_grant_valid drops on the next edge, and o_timeout=1 for exactly that one cycle.
  - The pointer advances as for a normal release.
  - A normal release in the same cycle as expiry takes precedence: no o_timeout pulse.
- Not defined: no counter is present, o_timeout is tied 0, and grants hold indefinitely.

Test Plan:
- Reset release with i_req=5'b11111 (N=5):
  - During reset, all outputs are 0.
  - First edge after reset deassert: o_grant_valid=1, o_grant_sel=0, o_grant_onehot=5'b00001.
- Single requester, i_req=5'b00100 from IDLE:
  - Next cycle: sel=2, onehot=5'b00100, held unchanged for 10 cycles.
  - Pulse i_release: valid=0 next cycle.
  - Re-request from all: the grant goes to index 3.
- Rotation and wrap, i_req=5'b11111 held, i_release pulsed on every grant:
  - Grant sequence is 0,1,2,3,4,0,1, with a 1-cycle valid=0 bubble between grants.
  - o_grant_sel never takes the values 5, 6 or 7.
- Withdrawal: while granted index 3, drop i_req[3] without i_release:
  - valid=0 next cycle.
  - With i_req=5'b00011 the next grant is 0 (pointer 4, wrap).
- Async reset mid-grant (sel=2): assert i_rst between clock edges:
  - Outputs go to 0 immediately.
  - After release of reset with i_req=5'b00100, grant is sel=2 (pointer back to 0).
- ARB_TIMEOUT_EN, MAX_HOLD=4, i_req=5'b00010 held, no i_release:
  - valid high exactly 4 cycles, then valid=0 with o_timeout=1 for that one cycle.
  - Re-grant to 1 after the bubble.
  - Repeat with i_release in the 4th cycle: o_timeout stays 0.
